// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time from a synchronous FIFO and
// serialises it as a UART frame (start, data LSB first, optional parity, stop).
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_last;

    assign baud_last    = (baud_q == BaudLast);
    // Read strobe decoded straight from the state register: exactly one cycle per word.
    assign fifo_rd_en_o = (state_q == StReq);
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    // Next-state, counter, shift register and registered-output logic.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty_i) state_d = StReq;
            end
            StReq: begin
                state_d = StLoad;
            end
            StLoad: begin
                // Read data is registered in the FIFO, so it is valid one cycle after the pop.
                shift_d = fifo_rdata_i;
                par_d   = (^fifo_rdata_i) ^ (PARITY_ODD != 0);
                baud_d  = '0;
                bit_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StParity: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are derived from the next state so the registers line up with the state.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StStop) && (baud_d == BaudLast);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one plain instance fed by a small FIFO model,
// plus even- and odd-parity instances sharing a simple single-word source.
module tb_fifo_uart_tx;

    localparam int unsigned Cpb = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // FIFO model for the plain instance.
    logic [7:0]  mem [0:15];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    int unsigned underflow = 0;
    logic [7:0]  rdata0 = 8'h00;
    logic        empty0;
    assign empty0 = (wr_cnt == rd_cnt);

    logic rd0, tx0, busy0, done0;

    // Shared source for the parity instances.
    logic       empty_p = 1'b1;
    logic [7:0] rdata_p = 8'hA5;
    logic rd_e, tx_e, busy_e, done_e;
    logic rd_o, tx_od, busy_o, done_o;

    int checks = 0;
    int failures = 0;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty0), .fifo_rdata_i(rdata0),
        .fifo_rd_en_o(rd0), .tx_o(tx0), .busy_o(busy0), .done_o(done0)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty_p), .fifo_rdata_i(rdata_p),
        .fifo_rd_en_o(rd_e), .tx_o(tx_e), .busy_o(busy_e), .done_o(done_e)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty_p), .fifo_rdata_i(rdata_p),
        .fifo_rd_en_o(rd_o), .tx_o(tx_od), .busy_o(busy_o), .done_o(done_o)
    );

    // Registered-read FIFO: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd0) begin
            if (wr_cnt == rd_cnt) underflow <= underflow + 1;
            else begin
                rdata0 <= mem[rd_cnt % 16];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_cnt % 16] = d;
        wr_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        push(8'hA5);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0 || done0 !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc=%0d tx/busy/rd/done got=%b%b%b%b exp=1000",
                         i, tx0, busy0, rd0, done0);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] fb;
        logic e_tx, e_busy, e_rd, e_done;
        fb = {1'b1, 8'hA5, 1'b0};
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            e_tx   = (k >= 2 && k <= 41) ? fb[(k - 2) / Cpb] : 1'b1;
            e_busy = (k <= 41);
            e_rd   = (k == 0);
            e_done = (k == 41);
            checks++;
            if ({tx0, busy0, rd0, done0} !== {e_tx, e_busy, e_rd, e_done}) begin
                failures++;
                $display("FAIL single k=%0d tx/busy/rd/done got=%b%b%b%b exp=%b%b%b%b",
                         k, tx0, busy0, rd0, done0, e_tx, e_busy, e_rd, e_done);
            end
        end
        checks++;
        if (rd_cnt != 1 || underflow != 0) begin
            failures++;
            $display("FAIL single pops got=%0d/%0d exp=1/0", rd_cnt, underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [9:0] fb;
        logic e_tx, e_busy, e_rd, e_done;
        int j, m;
        words = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) push(words[i]);
        // Period per word: REQ, LOAD, 40 frame cycles, one IDLE cycle.
        for (int k = 0; k < 3 * 43 + 20; k++) begin
            tick();
            j = k / 43;
            m = k % 43;
            if (j < 3) begin
                fb     = {1'b1, words[j], 1'b0};
                e_tx   = (m >= 2 && m <= 41) ? fb[(m - 2) / Cpb] : 1'b1;
                e_busy = (m != 42);
                e_rd   = (m == 0);
                e_done = (m == 41);
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
            end
            checks++;
            if ({tx0, busy0, rd0, done0} !== {e_tx, e_busy, e_rd, e_done}) begin
                failures++;
                $display("FAIL burst k=%0d tx/busy/rd/done got=%b%b%b%b exp=%b%b%b%b",
                         k, tx0, busy0, rd0, done0, e_tx, e_busy, e_rd, e_done);
            end
        end
        checks++;
        if (rd_cnt != 4 || underflow != 0) begin
            failures++;
            $display("FAIL burst pops got=%0d/%0d exp=4/0", rd_cnt, underflow);
        end
    endtask

    task automatic test_parity();
        logic [10:0] fbe, fbo;
        logic e_txe, e_txo, e_busy, e_rd, e_done;
        fbe = {1'b1, 1'b0, 8'hA5, 1'b0};
        fbo = {1'b1, 1'b1, 8'hA5, 1'b0};
        empty_p = 1'b0;
        for (int k = 0; k < 52; k++) begin
            tick();
            if (k == 0) empty_p = 1'b1;
            e_txe  = (k >= 2 && k <= 45) ? fbe[(k - 2) / Cpb] : 1'b1;
            e_txo  = (k >= 2 && k <= 45) ? fbo[(k - 2) / Cpb] : 1'b1;
            e_busy = (k <= 45);
            e_rd   = (k == 0);
            e_done = (k == 45);
            checks++;
            if ({tx_e, busy_e, rd_e, done_e} !== {e_txe, e_busy, e_rd, e_done}) begin
                failures++;
                $display("FAIL parity_even k=%0d tx/busy/rd/done got=%b%b%b%b exp=%b%b%b%b",
                         k, tx_e, busy_e, rd_e, done_e, e_txe, e_busy, e_rd, e_done);
            end
            checks++;
            if ({tx_od, busy_o, rd_o, done_o} !== {e_txo, e_busy, e_rd, e_done}) begin
                failures++;
                $display("FAIL parity_odd k=%0d tx/busy/rd/done got=%b%b%b%b exp=%b%b%b%b",
                         k, tx_od, busy_o, rd_o, done_o, e_txo, e_busy, e_rd, e_done);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] fb;
        logic e_tx;
        fb = {1'b1, 8'h5A, 1'b0};
        push(8'h5A);
        // Run into DATA bit 3 (cycles 18..21), then reset at cycle 20's edge.
        for (int k = 0; k < 20; k++) begin
            tick();
            e_tx = (k >= 2) ? fb[(k - 2) / Cpb] : 1'b1;
            checks++;
            if ({tx0, rd0, done0} !== {e_tx, (k == 0), 1'b0}) begin
                failures++;
                $display("FAIL midrst_pre k=%0d tx/rd/done got=%b%b%b exp=%b%b0",
                         k, tx0, rd0, done0, e_tx, (k == 0));
            end
        end
        rst = 1'b1;
        push(8'h81);
        for (int r = 0; r < 3; r++) begin
            tick();
            checks++;
            if ({tx0, busy0, rd0, done0} !== 4'b1000) begin
                failures++;
                $display("FAIL midrst_hold r=%0d tx/busy/rd/done got=%b%b%b%b exp=1000",
                         r, tx0, busy0, rd0, done0);
            end
        end
        rst = 1'b0;
        fb = {1'b1, 8'h81, 1'b0};
        for (int k = 0; k < 45; k++) begin
            tick();
            e_tx = (k >= 2 && k <= 41) ? fb[(k - 2) / Cpb] : 1'b1;
            checks++;
            if ({tx0, rd0, done0} !== {e_tx, (k == 0), (k == 41)}) begin
                failures++;
                $display("FAIL midrst_post k=%0d tx/rd/done got=%b%b%b exp=%b%b%b",
                         k, tx0, rd0, done0, e_tx, (k == 0), (k == 41));
            end
        end
        checks++;
        if (rd_cnt != 6 || underflow != 0) begin
            failures++;
            $display("FAIL midrst pops got=%0d/%0d exp=6/0", rd_cnt, underflow);
        end
    endtask

    task automatic test_empty();
        int rd_seen = 0;
        int tx_low = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (rd0 || rd_e || rd_o) rd_seen++;
            if (!tx0 || !tx_e || !tx_od) tx_low++;
        end
        checks++;
        if (rd_seen != 0) begin
            failures++;
            $display("FAIL empty rd_en cycles got=%0d exp=0", rd_seen);
        end
        checks++;
        if (tx_low != 0) begin
            failures++;
            $display("FAIL empty tx low cycles got=%0d exp=0", tx_low);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the synchronous FIFO. When the FIFO is not empty, it pops one word and serialises it onto an asynchronous UART line. The frame is a start bit, data LSB first, optional parity and one stop bit. It drives the FIFO's read strobe directly and captures the FIFO's registered read data one cycle after the pop.

## Interface
Parameters:
- WIDTH, 8, data word width; must match the FIFO's WIDTH.
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥ 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk_i  input  1  single clock; all state changes on its rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rdata_i  input  WIDTH  FIFO registered read data; valid in the cycle after a pop.
- fifo_rd_en_o  output  1  FIFO read strobe; high for exactly one cycle per word.
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- Reset (rst_i=1 at an edge) forces the following values after that edge:
  - state = IDLE, tx_o=1, busy_o=0, fifo_rd_en_o=0, done_o=0.
  - Bit counter = 0, baud counter = 0, shift register = 0.
- Reset mid-frame aborts the frame; the word in flight is discarded, not re-read.
- FSM states: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
  - IDLE: if fifo_empty_i=0, go to REQ; otherwise stay.
  - REQ: fifo_rd_en_o=1 (decoded from the state register, one cycle only); always go to LOAD.
  - LOAD: capture fifo_rdata_i into the shift register, compute parity over the captured word, go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_o = shift register bit 0 for CLKS_PER_BIT cycles per bit, then shift right. After WIDTH bits go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: tx_o = XOR of the data bits, XOR PARITY_ODD, for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles; done_o=1 on the final cycle; go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Its width is $clog2(CLKS_PER_BIT), minimum 1.
- The bit counter counts 0..WIDTH-1. Its width is $clog2(WIDTH), minimum 1.
- tx_o, busy_o and done_o are registered outputs; no combinational path from inputs to outputs.
- A pop is issued only from IDLE with fifo_empty_i=0, so the block never reads an empty FIFO. fifo_empty_i is ignored outside IDLE.
- Words sent = words popped, in FIFO order.

## Timing
- Frame length = CLKS_PER_BIT × (WIDTH + 2 + PARITY_EN) cycles, measured from the first START cycle to the last STOP cycle.
- Pop-to-start latency:
  - fifo_empty_i=0 is sampled in IDLE at edge N.
  - fifo_rd_en_o is high during cycle N+1 (REQ).
  - The data capture happens at the edge ending cycle N+2 (LOAD).
  - tx_o falls at the edge that starts cycle N+3.
- Back-to-back words: after STOP, IDLE, REQ and LOAD hold tx_o=1 for 3 extra cycles. The inter-frame gap is therefore stop bit + 3 cycles, fixed.
- If the FIFO becomes non-empty during a frame, the next pop waits until IDLE is re-entered.
- busy_o rises in the first REQ cycle and falls in the first IDLE cycle after STOP.

## Test plan
- Reset: hold rst_i=1 for 3 cycles with fifo_empty_i=0 → tx_o=1, busy_o=0, fifo_rd_en_o=0, done_o=0 throughout.
- Single byte (CLKS_PER_BIT=4, PARITY_EN=0): FIFO holds 0xA5.
  - Expect exactly one fifo_rd_en_o pulse.
  - tx_o sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1 (40 cycles).
  - done_o pulses once on cycle 40; busy_o falls the next cycle.
- Parity: 0xA5 with PARITY_EN=1.
  - PARITY_ODD=0 → parity bit 0.
  - PARITY_ODD=1 → parity bit 1.
  - Frame length is 44 cycles in both cases.
- Burst: FIFO preloaded with 0x00, 0xFF, 0x3C.
  - Expect three frames in order, three rd_en pulses and no read while empty.
  - Gap from each STOP end to the next START is exactly 3 cycles.
  - No further pop once fifo_empty_i=1.
- Reset mid-frame: assert rst_i during DATA bit 3 of 0x5A.
  - tx_o=1 and busy_o=0 after the reset edge.
  - No done_o pulse; the next pop occurs only after rst_i is released and fifo_empty_i=0.
- Empty FIFO: hold fifo_empty_i=1 for 100 cycles → fifo_rd_en_o never asserted, tx_o stays 1.
